// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding select encodings, hazard FSM states, PC register number.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EXE = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // r15 is the PC; its value never comes from the bypass network
    localparam int REG_PC = 15;

endpackage

// File: rtl/fwd_select_unit.sv
// Per-operand bypass select: youngest matching producer wins (EXE > MEM > WB > RF).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the select simply follows its inputs.
module fwd_select_unit
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS = 4
) (
    input  logic [REG_BITS-1:0] src_i,
    input  logic                use_i,
    input  logic [REG_BITS-1:0] exe_rd_i,
    input  logic                exe_we_i,
    input  logic [REG_BITS-1:0] mem_rd_i,
    input  logic                mem_we_i,
    input  logic [REG_BITS-1:0] wb_rd_i,
    input  logic                wb_we_i,
    output fwd_sel_t            sel_o
);

    logic src_ok;

    assign src_ok = use_i && (src_i != REG_BITS'(REG_PC));

    // Priority mux: the stage closest to ID holds the newest value
    always_comb begin
        sel_o = FWD_RF;
        if (src_ok && exe_we_i && (exe_rd_i == src_i)) begin
            sel_o = FWD_EXE;
        end else if (src_ok && mem_we_i && (mem_rd_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (src_ok && wb_we_i && (wb_rd_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard control: forwarding selects, load-use bubble, branch flush, memory-wait freeze, stall counter.
// Latency: control outputs are combinational (zero cycles); state, flush count and stall_count are registered.
// Backpressure: mem_busy freezes the whole pipe; load-use stalls PC and IF/ID for one cycle.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS     = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] ID_Rn,
    input  logic [REG_BITS-1:0] ID_Rm,
    input  logic                ID_use_Rn,
    input  logic                ID_use_Rm,
    input  logic                ID_branch_taken,
    input  logic [REG_BITS-1:0] EXE_Rd_num,
    input  logic                EXE_RF_enable,
    input  logic                EXE_load_instr,
    input  logic [REG_BITS-1:0] MEM_Rd_num,
    input  logic                MEM_RF_enable,
    input  logic [REG_BITS-1:0] WB_Rd_num,
    input  logic                WB_RF_enable,
    input  logic                mem_busy,
    output logic                PC_ld,
    output logic                IFID_ld,
    output logic                IFID_flush,
    output logic                IDEXE_bubble,
    output logic                pipe_freeze,
    output logic [1:0]          fwdA_sel,
    output logic [1:0]          fwdB_sel,
    output logic [CNT_W-1:0]    stall_count
);

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q;
    fwd_sel_t         fwd_a, fwd_b;
    logic             load_use;

    fwd_select_unit #(.REG_BITS(REG_BITS)) u_fwd_a (
        .src_i    (ID_Rn),
        .use_i    (ID_use_Rn),
        .exe_rd_i (EXE_Rd_num),
        .exe_we_i (EXE_RF_enable),
        .mem_rd_i (MEM_Rd_num),
        .mem_we_i (MEM_RF_enable),
        .wb_rd_i  (WB_Rd_num),
        .wb_we_i  (WB_RF_enable),
        .sel_o    (fwd_a)
    );

    fwd_select_unit #(.REG_BITS(REG_BITS)) u_fwd_b (
        .src_i    (ID_Rm),
        .use_i    (ID_use_Rm),
        .exe_rd_i (EXE_Rd_num),
        .exe_we_i (EXE_RF_enable),
        .mem_rd_i (MEM_Rd_num),
        .mem_we_i (MEM_RF_enable),
        .wb_rd_i  (WB_Rd_num),
        .wb_we_i  (WB_RF_enable),
        .sel_o    (fwd_b)
    );

    // A load in EXE cannot be bypassed yet; an EXE match on either operand means wait one cycle
    assign load_use = EXE_load_instr && ((fwd_a == FWD_EXE) || (fwd_b == FWD_EXE));

    assign fwdA_sel    = reset ? FWD_RF : fwd_a;
    assign fwdB_sel    = reset ? FWD_RF : fwd_b;
    assign stall_count = stall_count_q;

    // State, flush countdown and saturating stall counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!PC_ld && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

    // Next state: FREEZE behaves like RUN once memory releases, so both share the hazard decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN, ST_FREEZE: begin
                if (mem_busy) begin
                    state_d = ST_FREEZE;
                    cnt_d   = 2'd0;
                end else if (load_use) begin
                    state_d = ST_RUN;
                end else if (ID_branch_taken && (FLUSH_CYCLES > 1)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = 2'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (mem_busy) begin
                    state_d = ST_FREEZE;
                    cnt_d   = 2'd0;
                end else if (cnt_q > 2'd1) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Outputs: priority mem_busy > load-use > branch; while flushing, ID holds a squashed slot so hazards are ignored
    always_comb begin
        PC_ld        = 1'b1;
        IFID_ld      = 1'b1;
        IFID_flush   = 1'b0;
        IDEXE_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (reset) begin
            PC_ld   = 1'b0;
            IFID_ld = 1'b0;
        end else if (mem_busy) begin
            PC_ld       = 1'b0;
            IFID_ld     = 1'b0;
            pipe_freeze = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            IFID_flush = (cnt_q != 2'd0);
        end else if (load_use) begin
            PC_ld        = 1'b0;
            IFID_ld      = 1'b0;
            IDEXE_bubble = 1'b1;
        end else if (ID_branch_taken) begin
            IFID_flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=2 and CNT_W=4.
// Inputs are driven on the falling edge; outputs are checked 2 time units later.
// Expected results are queued when stimulus is applied and popped at the check point.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ID_Rn, ID_Rm, EXE_Rd_num, MEM_Rd_num, WB_Rd_num;
    logic       ID_use_Rn, ID_use_Rm, ID_branch_taken;
    logic       EXE_RF_enable, EXE_load_instr, MEM_RF_enable, WB_RF_enable, mem_busy;
    logic       PC_ld, IFID_ld, IFID_flush, IDEXE_bubble, pipe_freeze;
    logic [1:0] fwdA_sel, fwdB_sel;
    logic [3:0] stall_count;

    // Control vector order: {PC_ld, IFID_ld, IFID_flush, IDEXE_bubble, pipe_freeze}
    localparam logic [4:0] C_NORM  = 5'b11000;
    localparam logic [4:0] C_FLUSH = 5'b11100;
    localparam logic [4:0] C_LDUSE = 5'b00010;
    localparam logic [4:0] C_FRZ   = 5'b00001;
    localparam logic [4:0] C_RST   = 5'b00000;

    typedef struct packed {
        logic [4:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] sc;
    } exp_t;

    exp_t  sbq[$];
    string tagq[$];
    int    checks = 0;
    int    passed = 0;
    logic [3:0] exp_sc = 4'd0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_BITS(4), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_Rn           (ID_Rn),
        .ID_Rm           (ID_Rm),
        .ID_use_Rn       (ID_use_Rn),
        .ID_use_Rm       (ID_use_Rm),
        .ID_branch_taken (ID_branch_taken),
        .EXE_Rd_num      (EXE_Rd_num),
        .EXE_RF_enable   (EXE_RF_enable),
        .EXE_load_instr  (EXE_load_instr),
        .MEM_Rd_num      (MEM_Rd_num),
        .MEM_RF_enable   (MEM_RF_enable),
        .WB_Rd_num       (WB_Rd_num),
        .WB_RF_enable    (WB_RF_enable),
        .mem_busy        (mem_busy),
        .PC_ld           (PC_ld),
        .IFID_ld         (IFID_ld),
        .IFID_flush      (IFID_flush),
        .IDEXE_bubble    (IDEXE_bubble),
        .pipe_freeze     (pipe_freeze),
        .fwdA_sel        (fwdA_sel),
        .fwdB_sel        (fwdB_sel),
        .stall_count     (stall_count)
    );

    task automatic clr_in();
        ID_Rn = 4'd0; ID_Rm = 4'd0; ID_use_Rn = 1'b0; ID_use_Rm = 1'b0;
        ID_branch_taken = 1'b0;
        EXE_Rd_num = 4'd0; EXE_RF_enable = 1'b0; EXE_load_instr = 1'b0;
        MEM_Rd_num = 4'd0; MEM_RF_enable = 1'b0;
        WB_Rd_num = 4'd0; WB_RF_enable = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic cmp(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, expv);
    endtask

    // Queue the expectation for the cycle just driven, then check it mid-cycle
    task automatic chk(input string tag, input logic [4:0] ctl, input logic [1:0] efa, input logic [1:0] efb);
        exp_t  e;
        string t;
        e.ctl = ctl; e.fa = efa; e.fb = efb; e.sc = exp_sc;
        sbq.push_back(e);
        tagq.push_back(tag);
        #2;
        e = sbq.pop_front();
        t = tagq.pop_front();
        cmp(t, "PC_ld",        8'(PC_ld),        8'(e.ctl[4]));
        cmp(t, "IFID_ld",      8'(IFID_ld),      8'(e.ctl[3]));
        cmp(t, "IFID_flush",   8'(IFID_flush),   8'(e.ctl[2]));
        cmp(t, "IDEXE_bubble", 8'(IDEXE_bubble), 8'(e.ctl[1]));
        cmp(t, "pipe_freeze",  8'(pipe_freeze),  8'(e.ctl[0]));
        cmp(t, "fwdA_sel",     8'(fwdA_sel),     8'(e.fa));
        cmp(t, "fwdB_sel",     8'(fwdB_sel),     8'(e.fb));
        cmp(t, "stall_count",  8'(stall_count),  8'(e.sc));
        // Reference stall counter: one per expected PC_ld=0 cycle outside reset, saturating at 15
        if (!reset && !e.ctl[4] && exp_sc != 4'hF) exp_sc = exp_sc + 4'd1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        exp_sc = 4'd0;
        chk(tag, C_RST, 2'b00, 2'b00);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr_in();
        // Reset gates forwarding even with a live match
        ID_use_Rn = 1'b1; ID_Rn = 4'd3; EXE_Rd_num = 4'd3; EXE_RF_enable = 1'b1;
        @(negedge clk);
        chk("reset_state", C_RST, 2'b00, 2'b00);

        @(negedge clk); reset = 1'b0;
        chk("fwd_exe", C_NORM, 2'b01, 2'b00);
        @(negedge clk); MEM_Rd_num = 4'd3; MEM_RF_enable = 1'b1;
        chk("fwd_exe_over_mem", C_NORM, 2'b01, 2'b00);
        @(negedge clk); EXE_RF_enable = 1'b0; WB_Rd_num = 4'd3; WB_RF_enable = 1'b1;
        chk("fwd_mem_over_wb", C_NORM, 2'b10, 2'b00);
        @(negedge clk); MEM_RF_enable = 1'b0;
        chk("fwd_wb", C_NORM, 2'b11, 2'b00);
        @(negedge clk); clr_in(); ID_use_Rm = 1'b1; ID_Rm = 4'd7; WB_Rd_num = 4'd7; WB_RF_enable = 1'b1;
        ID_use_Rn = 1'b1; ID_Rn = 4'd2;
        chk("fwdB_wb", C_NORM, 2'b00, 2'b11);
        @(negedge clk); clr_in(); ID_use_Rn = 1'b1; ID_Rn = 4'd15; EXE_Rd_num = 4'd15; EXE_RF_enable = 1'b1;
        chk("r15_no_fwd", C_NORM, 2'b00, 2'b00);
        @(negedge clk); clr_in(); ID_Rn = 4'd3; EXE_Rd_num = 4'd3; EXE_RF_enable = 1'b1;
        chk("unused_src", C_NORM, 2'b00, 2'b00);

        // Load-use on Rm, then the load moves to MEM
        @(negedge clk); clr_in(); ID_use_Rm = 1'b1; ID_Rm = 4'd5;
        EXE_Rd_num = 4'd5; EXE_RF_enable = 1'b1; EXE_load_instr = 1'b1;
        chk("loaduse", C_LDUSE, 2'b00, 2'b01);
        @(negedge clk); clr_in(); ID_use_Rm = 1'b1; ID_Rm = 4'd5; MEM_Rd_num = 4'd5; MEM_RF_enable = 1'b1;
        chk("loaduse_resolved", C_NORM, 2'b00, 2'b10);

        // Taken branch with two flush cycles
        @(negedge clk); clr_in(); ID_branch_taken = 1'b1;
        chk("branch_1", C_FLUSH, 2'b00, 2'b00);
        @(negedge clk); clr_in();
        chk("branch_2", C_FLUSH, 2'b00, 2'b00);
        @(negedge clk);
        chk("branch_done", C_NORM, 2'b00, 2'b00);

        // Branch during load-use is ignored, then re-presented
        @(negedge clk); clr_in(); ID_branch_taken = 1'b1; ID_use_Rn = 1'b1; ID_Rn = 4'd9;
        EXE_Rd_num = 4'd9; EXE_RF_enable = 1'b1; EXE_load_instr = 1'b1;
        chk("ldu_branch", C_LDUSE, 2'b01, 2'b00);
        @(negedge clk); clr_in(); ID_branch_taken = 1'b1; ID_use_Rn = 1'b1; ID_Rn = 4'd9;
        MEM_Rd_num = 4'd9; MEM_RF_enable = 1'b1;
        chk("ldu_branch_re", C_FLUSH, 2'b10, 2'b00);
        @(negedge clk); clr_in();
        chk("ldu_branch_2", C_FLUSH, 2'b00, 2'b00);
        @(negedge clk);
        chk("ldu_branch_end", C_NORM, 2'b00, 2'b00);

        // Freeze over a pending load-use: 4 freeze cycles, bubble after release
        do_reset("reset_before_freeze");
        for (int i = 0; i < 4; i++) begin
            clr_in(); ID_use_Rm = 1'b1; ID_Rm = 4'd5;
            EXE_Rd_num = 4'd5; EXE_RF_enable = 1'b1; EXE_load_instr = 1'b1; mem_busy = 1'b1;
            chk($sformatf("freeze_%0d", i), C_FRZ, 2'b00, 2'b01);
            @(negedge clk);
        end
        mem_busy = 1'b0;
        chk("freeze_release_bubble", C_LDUSE, 2'b00, 2'b01);
        @(negedge clk); clr_in(); ID_use_Rm = 1'b1; ID_Rm = 4'd5; MEM_Rd_num = 4'd5; MEM_RF_enable = 1'b1;
        chk("freeze_resolved_sc5", C_NORM, 2'b00, 2'b10);

        // mem_busy during FLUSH discards the remaining flush
        @(negedge clk); clr_in(); ID_branch_taken = 1'b1;
        chk("flush_then_busy_1", C_FLUSH, 2'b00, 2'b00);
        @(negedge clk); clr_in(); mem_busy = 1'b1;
        chk("flush_busy", C_FRZ, 2'b00, 2'b00);
        @(negedge clk); clr_in();
        chk("flush_discarded", C_NORM, 2'b00, 2'b00);

        // Reset mid-FLUSH
        @(negedge clk); clr_in(); ID_branch_taken = 1'b1;
        chk("pre_rst_flush", C_FLUSH, 2'b00, 2'b00);
        clr_in();
        do_reset("rst_mid_flush");
        chk("after_rst_flush", C_NORM, 2'b00, 2'b00);

        // Reset mid-FREEZE
        @(negedge clk); clr_in(); mem_busy = 1'b1;
        chk("pre_rst_freeze", C_FRZ, 2'b00, 2'b00);
        mem_busy = 1'b0;
        do_reset("rst_mid_freeze");
        chk("after_rst_freeze", C_NORM, 2'b00, 2'b00);

        // Saturation of the 4-bit stall counter
        for (int i = 0; i < 18; i++) begin
            @(negedge clk); clr_in(); mem_busy = 1'b1;
            chk($sformatf("sat_%0d", i), C_FRZ, 2'b00, 2'b00);
        end
        @(negedge clk); clr_in();
        chk("sat_hold", C_NORM, 2'b00, 2'b00);
        @(negedge clk);
        chk("sat_final", C_NORM, 2'b00, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
